// File: rtl/nfi_scheduler.sv
// Generation-step scheduler for the Game of Life field engine: paces iterations
// by speed level, supports pause/single-step and a go/done handshake.
module nfi_scheduler #(
  parameter int BASE_PERIOD   = 4,
  parameter int NUM_SPEEDS    = 3,
  parameter int DEFAULT_SPEED = 0,
  parameter bit START_PAUSED  = 1'b0,
  parameter int GEN_W         = 16,
  localparam int SPEED_W      = (NUM_SPEEDS > 1) ? $clog2(NUM_SPEEDS) : 1,
  localparam int SLOW_PERIOD  = BASE_PERIOD << (NUM_SPEEDS - 1),
  localparam int CNT_W        = (SLOW_PERIOD > 1) ? $clog2(SLOW_PERIOD) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_cmd_toggle_pause,
  input  logic               i_cmd_step,
  input  logic               i_cmd_faster,
  input  logic               i_cmd_slower,
  input  logic               i_nfi_allowed,
  input  logic               i_nfi_done,
  output logic               o_go,
  output logic               o_busy,
  output logic               o_paused,
  output logic [SPEED_W-1:0] o_speed,
  output logic [GEN_W-1:0]   o_gen_cnt
);

  typedef enum logic [1:0] {S_COUNT, S_FIRE, S_WAIT} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_last;
  logic               toggle_q, step_q, faster_q, slower_q;
  logic               toggle_e, step_e, faster_e, slower_e;
  logic               spd_up, spd_dn, count_en;

  assign toggle_e = i_cmd_toggle_pause & ~toggle_q;
  assign step_e   = i_cmd_step         & ~step_q;
  assign faster_e = i_cmd_faster       & ~faster_q;
  assign slower_e = i_cmd_slower       & ~slower_q;

  // Only an actual level change counts; saturated or opposing presses do nothing.
  assign spd_up   = faster_e & ~slower_e & (o_speed != SPEED_W'(NUM_SPEEDS - 1));
  assign spd_dn   = slower_e & ~faster_e & (o_speed != '0);
  assign count_en = ~o_paused & i_nfi_allowed;

  // Terminal count of the current level: P(s) - 1 with P(s) = BASE << (N-1-s).
  assign cnt_last = CNT_W'((BASE_PERIOD << (NUM_SPEEDS - 1 - int'(o_speed))) - 1);

  assign o_go   = (state == S_FIRE);
  assign o_busy = (state != S_COUNT);

  // NOTE: all state updates use non-blocking assignments so every register
  // samples pre-edge values, matching the flop behaviour in simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_COUNT;
      cnt       <= '0;
      toggle_q  <= 1'b0;
      step_q    <= 1'b0;
      faster_q  <= 1'b0;
      slower_q  <= 1'b0;
      o_paused  <= START_PAUSED;
      o_speed   <= SPEED_W'(DEFAULT_SPEED);
      o_gen_cnt <= '0;
    end else begin
      toggle_q <= i_cmd_toggle_pause;
      step_q   <= i_cmd_step;
      faster_q <= i_cmd_faster;
      slower_q <= i_cmd_slower;

      if (toggle_e) o_paused <= ~o_paused;

      if (spd_up)      o_speed <= o_speed + SPEED_W'(1);
      else if (spd_dn) o_speed <= o_speed - SPEED_W'(1);

      case (state)
        S_COUNT: begin
          // Priority: paused step, then speed change, then normal counting.
          if (step_e && o_paused) begin
            cnt   <= '0;
            state <= S_FIRE;
          end else if (spd_up || spd_dn) begin
            cnt <= '0;
          end else if (count_en) begin
            if (cnt == cnt_last) begin
              cnt   <= '0;
              state <= S_FIRE;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        S_FIRE: state <= S_WAIT;
        S_WAIT: begin
          if (i_nfi_done) begin
            o_gen_cnt <= o_gen_cnt + GEN_W'(1);
            cnt       <= '0;
            state     <= S_COUNT;
          end
        end
        default: state <= S_COUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_nfi_scheduler.sv
// Directed bench for nfi_scheduler at default parameters (P = 16 / 8 / 4);
// inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_nfi_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       toggle, step, faster, slower, allowed, done;
  logic       go, busy, paused;
  logic [1:0] speed;
  logic [15:0] gen_cnt;

  int n_vec = 0;
  int n_err = 0;
  int n;
  int g;

  nfi_scheduler dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .i_cmd_toggle_pause (toggle),
    .i_cmd_step         (step),
    .i_cmd_faster       (faster),
    .i_cmd_slower       (slower),
    .i_nfi_allowed      (allowed),
    .i_nfi_done         (done),
    .o_go               (go),
    .o_busy             (busy),
    .o_paused           (paused),
    .o_speed            (speed),
    .o_gen_cnt          (gen_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycles until o_go is seen; returns budget on timeout.
  task automatic wait_go(input int budget, output int cycles);
    cycles = 0;
    while (!go && cycles < budget) begin
      tick();
      cycles++;
    end
  endtask

  task automatic count_go(input int cycles, output int gos);
    gos = 0;
    repeat (cycles) begin
      tick();
      if (go) gos++;
    end
  endtask

  // Called in the FIRE cycle: two WAIT cycles, then done is seen.
  task automatic engine_done();
    tick();
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  // 0 toggle, 1 step, 2 faster, 3 slower, 4 faster+slower together.
  task automatic press(input int which);
    case (which)
      0: toggle = 1'b1;
      1: step   = 1'b1;
      2: faster = 1'b1;
      3: slower = 1'b1;
      default: begin faster = 1'b1; slower = 1'b1; end
    endcase
    tick();
    toggle = 1'b0; step = 1'b0; faster = 1'b0; slower = 1'b0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; toggle = 1'b0; step = 1'b0; faster = 1'b0; slower = 1'b0;
    allowed = 1'b1; done = 1'b0;
    #22;
    check("rst_go",     go,      0);
    check("rst_busy",   busy,    0);
    check("rst_paused", paused,  0);
    check("rst_speed",  speed,   0);
    check("rst_gen",    gen_cnt, 0);
    tick();
    rst_n = 1'b1;

    // Free run at the slowest level.
    wait_go(100, n);
    check("first_go_lat", n, 16);
    check("busy_fire", busy, 1);
    engine_done();
    check("busy_after_done", busy, 0);
    check("gen_1", gen_cnt, 1);
    wait_go(100, n);
    check("go_interval_slow", n, 16);
    engine_done();
    check("gen_2", gen_cnt, 2);

    // Speed up to saturation.
    press(2); check("speed_up1", speed, 1);
    press(2); check("speed_up2", speed, 2);
    press(2); check("speed_sat_hi", speed, 2);
    wait_go(100, n);
    check("go_after_sat", n, 1);
    engine_done();
    wait_go(100, n);
    check("go_interval_fast", n, 4);
    engine_done();
    check("gen_4", gen_cnt, 4);

    // Slow down to saturation, then opposing presses must not clear cnt.
    press(3); press(3); press(3);
    check("speed_sat_lo", speed, 0);
    press(4);
    check("speed_both", speed, 0);
    wait_go(100, n);
    check("go_no_clear_both", n, 11);
    engine_done();
    check("gen_5", gen_cnt, 5);

    // Pause, idle, single step with held command.
    press(0);
    check("paused_on", paused, 1);
    count_go(100, g);
    check("no_go_paused", g, 0);
    step = 1'b1;
    tick();
    check("step_go", go, 1);
    engine_done();
    count_go(6, g);
    step = 1'b0;
    check("step_held_once", g, 0);
    check("gen_6", gen_cnt, 6);
    press(0);
    check("paused_off", paused, 0);
    press(1);
    wait_go(100, n);
    check("step_unpaused_ignored", n, 13);
    engine_done();
    check("gen_7", gen_cnt, 7);

    // Allowed gating holds the counter at 5.
    repeat (5) tick();
    allowed = 1'b0;
    count_go(20, g);
    check("no_go_blocked", g, 0);
    allowed = 1'b1;
    wait_go(100, n);
    check("go_after_allowed", n, 11);
    engine_done();
    check("gen_8", gen_cnt, 8);

    // WAIT with withheld done, toggle and step edges.
    wait_go(100, n);
    check("go_before_wait", n, 16);
    tick();
    press(0);
    press(1);
    count_go(45, g);
    check("no_go_in_wait", g, 0);
    check("busy_in_wait", busy, 1);
    check("paused_in_wait", paused, 1);
    check("gen_held_wait", gen_cnt, 8);
    done = 1'b1;
    tick();
    done = 1'b0;
    check("gen_9", gen_cnt, 9);
    done = 1'b1;
    tick();
    done = 1'b0;
    check("done_in_count_ignored", gen_cnt, 9);
    count_go(5, g);
    check("no_queued_step", g, 0);

    // Reset in the middle of WAIT.
    press(2);
    check("speed_before_rst", speed, 1);
    step = 1'b1;
    tick();
    step = 1'b0;
    check("go_before_rst", go, 1);
    tick();
    check("busy_before_rst", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_go",     go,      0);
    check("mid_rst_busy",   busy,    0);
    check("mid_rst_paused", paused,  0);
    check("mid_rst_speed",  speed,   0);
    check("mid_rst_gen",    gen_cnt, 0);
    #1;
    rst_n = 1'b1;
    done = 1'b1;
    tick();
    done = 1'b0;
    check("late_done_ignored", gen_cnt, 0);
    check("busy_after_rst", busy, 0);
    wait_go(100, n);
    check("go_after_rst", n, 15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/nfi_scheduler.md
Name: nfi_scheduler

Overview:
- Parametrised successor of the next-field-iteration controller. Schedules generation steps of the Game of Life field engine.
- Adds selectable speed levels, single-step while paused, a go/done handshake with the field iterator, and a generation counter.
- Sits between the button/command decoder and the field iteration engine. Status outputs feed the display/HUD logic.

Parameters:
- BASE_PERIOD, 4: clock cycles between steps at the fastest speed; must be ≥1.
- NUM_SPEEDS, 3: number of speed levels, ≥1. Period of level s is P(s) = BASE_PERIOD << (NUM_SPEEDS-1-s); level NUM_SPEEDS-1 is fastest.
- DEFAULT_SPEED, 0: speed level loaded at reset; must be < NUM_SPEEDS.
- START_PAUSED, 0: reset value of the pause flag.
- GEN_W, 16: width of the generation counter.
- Derived locals: SPEED_W = max(1, $clog2(NUM_SPEEDS)); CNT_W = $clog2(P(0)).

Ports:
- clk  in  1  system clock, all logic on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- i_cmd_toggle_pause  in  1  level command; each rising edge toggles pause.
- i_cmd_step  in  1  level command; a rising edge requests one step (honoured only while paused).
- i_cmd_faster  in  1  level command; a rising edge raises the speed level.
- i_cmd_slower  in  1  level command; a rising edge lowers the speed level.
- i_nfi_allowed  in  1  engine may be scheduled; when low, the period counter holds.
- i_nfi_done  in  1  one-cycle pulse from the engine: iteration finished.
- o_go  out  1  one-cycle pulse: start one iteration.
- o_busy  out  1  high while in FIRE or WAIT.
- o_paused  out  1  current pause flag.
- o_speed  out  SPEED_W  current speed level.
- o_gen_cnt  out  GEN_W  completed generations; wraps at 2^GEN_W.

Behaviour:
- Reset values (async, while rst_n=0):
  - state = COUNT, cnt = 0, o_go = 0, o_busy = 0.
  - o_paused = START_PAUSED, o_speed = DEFAULT_SPEED, o_gen_cnt = 0.
  - All edge-detect history registers = 0. A command held high at reset release therefore counts as one press on the first clock.
- Edge detect: a command is the input high with its previous-cycle sample low. All four command inputs are edge-detected independently.
- Pause: a toggle edge inverts o_paused on the next edge. This applies in any state.
- Speed:
  - A faster edge increments o_speed, saturating at NUM_SPEEDS-1.
  - A slower edge decrements o_speed, saturating at 0.
  - Faster and slower edges in the same cycle: no change.
  - Any actual level change in COUNT clears cnt to 0, and no FIRE occurs that cycle.
- State COUNT:
  - Counting is enabled when (!o_paused && i_nfi_allowed).
  - Enabled and cnt == P(o_speed)-1: cnt <= 0, go to FIRE.
  - Enabled otherwise: cnt <= cnt + 1.
  - Not enabled: cnt holds.
  - Step edge while o_paused == 1 (registered value): go to FIRE, cnt <= 0. This does not require i_nfi_allowed.
  - Step edge while not paused: ignored.
- State FIRE: o_go = 1 for exactly this one cycle, then unconditionally go to WAIT.
- State WAIT:
  - Hold until i_nfi_done = 1, then o_gen_cnt <= o_gen_cnt + 1 and go to COUNT with cnt = 0.
  - Pausing during WAIT does not abort; the in-flight iteration completes.
- Ignored inputs:
  - i_nfi_done in COUNT or FIRE is ignored.
  - Step edges in FIRE or WAIT are ignored, not queued.
- Simultaneous events in COUNT:
  - Toggle and step edges together while paused: FIRE is taken and o_paused becomes 0.
  - Speed change together with a counter terminal: the speed change wins (cnt <= 0, no FIRE).
  - Step edge together with a speed change while paused: FIRE is taken.
- Timing: each FIRE→WAIT→COUNT→FIRE loop takes P(s) counting cycles + 1 FIRE cycle + the WAIT duration.
- Reset mid-operation: immediate return to reset values; any pending iteration is abandoned.
- o_go and o_busy are decoded from state, so they have no extra latency.

Test Plan (defaults: BASE_PERIOD=4, NUM_SPEEDS=3, so P = 16 / 8 / 4):
- Free run: release reset, allowed=1, done pulsed 2 cycles after each go -> first o_go 16 cycles after reset release; subsequent go pulses every 19 cycles; o_gen_cnt = 1, 2, 3…; o_busy high 3 cycles per loop.
- Speed: press faster twice, then faster once more -> o_speed 0→1→2 and stays 2; go interval 4+1+2 = 7 cycles. Press slower three times -> o_speed 0. Faster and slower pressed in the same cycle -> no change, cnt not cleared.
- Pause/step: toggle -> o_paused = 1; no o_go for 100 cycles; step edge -> o_go on the next cycle. Step held high 10 cycles -> exactly one go. Step while unpaused -> no extra go.
- Allowed gating: drop i_nfi_allowed at cnt = 5 for 20 cycles -> cnt holds at 5; go fires 11 enabled cycles after allowed returns.
- WAIT robustness: withhold done for 50 cycles while issuing toggle and step edges -> no second go; o_paused toggles; after done, o_gen_cnt increments once.
- Reset mid-WAIT: assert rst_n = 0 -> all outputs return to reset values asynchronously; a late i_nfi_done after release does not increment o_gen_cnt.
